fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register directly upstream of the control decoder.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Captures returned words into the IF/ID register and drives the 6-bit opcode field consumed by the decoder.
- Handles stall from the hazard unit and redirect (taken branch/jump) from later stages, using a one-entry skid buffer and a drain state.

---
 rtl/mips_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 15 +
 rtl/if_id_register.sv | 31 +++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_RESET_DEF = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;

  // Opcode field position inside an instruction word
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  // Instruction addresses are always word aligned
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus. Memory answers in the cycle it
// raises imem_ready, so rdata is only meaningful when req and ready are both 1.
interface fetch_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline payload register. Flush clears the instruction (leaving a
// nop), and beats hold so a redirect always wins over a stall.
module if_id_register
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   flush_i,
  input  logic   hold_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t payload_q;

  // Payload update: flush > hold > load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      payload_q <= '0;
    end else if (flush_i) begin
      payload_q.valid <= 1'b0;
      payload_q.instr <= NOP_INSTR;
    end else if (!hold_i && load_i) begin
      payload_q <= d_i;
    end
  end

  assign q_o = payload_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory request FSM, one-entry skid buffer and
// the IF/ID register feeding the control decoder.
//
// state | meaning
// BOOT  | first cycle after reset, no request issued
// FETCH | request at pc every cycle; responses go to IF/ID
// HOLD  | stalled with a fetched word parked in the skid buffer
// DRAIN | redirect seen mid-request; waiting to throw away the stale word
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = PC_RESET_DEF
)(
  input  logic                  clk,
  input  logic                  reset,
  fetch_stage_if.master         imem,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  if_id_valid,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic [5:0]            if_id_op
);

  fetch_state_e          state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] target_q;
  if_id_t                skid_q;
  logic                  req_q;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] redir_aligned;
  logic                  ifid_load;
  logic                  ifid_flush;
  logic                  ifid_hold;
  if_id_t                ifid_d;
  if_id_t                ifid_q;

  // pc + 4 wraps naturally at the top of the address space
  assign pc_plus4      = pc_q + DATA_WIDTH'(4);
  assign redir_aligned = align_word(redirect_pc);

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  // IF/ID control: what the pipeline register does this cycle
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    ifid_d     = '0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else if (imem.imem_ready) begin
          ifid_load = 1'b1;
          ifid_d    = {1'b1, imem.imem_rdata, pc_plus4};
        end else begin
          ifid_load = 1'b1;    // bubble while memory is waiting
        end
      end
      HOLD: begin
        if (redirect) begin
          ifid_flush = 1'b1;
        end else if (stall) begin
          ifid_hold = 1'b1;
        end else begin
          ifid_load    = 1'b1;
          ifid_d       = skid_q;
          ifid_d.valid = 1'b1;
        end
      end
      DRAIN: begin
        if (redirect) ifid_flush = 1'b1;
        else          ifid_hold  = 1'b1;
      end
      default: ifid_hold = 1'b1;
    endcase
  end

  // Fetch FSM with PC, skid buffer, saved redirect target and registered req
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= PC_RESET;
      target_q <= '0;
      skid_q   <= '0;
      req_q    <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem.imem_ready) begin
            if (redirect) begin
              pc_q <= redir_aligned;
            end else if (stall) begin
              pc_q    <= pc_plus4;
              skid_q  <= {1'b1, imem.imem_rdata, pc_plus4};
              state_q <= HOLD;
              req_q   <= 1'b0;
            end else begin
              pc_q <= pc_plus4;
            end
          end else if (redirect) begin
            // request still in flight: keep the address stable until it lands
            target_q <= redir_aligned;
            state_q  <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_q    <= redir_aligned;
            skid_q  <= '0;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end else if (!stall) begin
            skid_q  <= '0;
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        DRAIN: begin
          if (redirect) target_q <= redir_aligned;
          if (imem.imem_ready) begin
            pc_q    <= redirect ? redir_aligned : target_q;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  if_id_register u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .hold_i  (ifid_hold),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign if_id_valid    = ifid_q.valid;
  assign if_id_instr    = ifid_q.instr;
  assign if_id_pc_plus4 = ifid_q.pc_plus4;
  assign if_id_op       = if_id_instr[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Memory word for address a is
// {a[7:2], a[25:0]} unless overridden, so the opcode equals the word index.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  if_id_op;
  logic        ovr_en;
  logic [31:0] ovr_word;
  int          total;
  int          bad;

  fetch_stage_if #(.DATA_WIDTH(32)) bus ();

  assign bus.imem_rdata = ovr_en ? ovr_word : {bus.imem_addr[7:2], bus.imem_addr[25:0]};

  fetch_stage #(.DATA_WIDTH(32), .PC_RESET(32'h0040_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (bus),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_op       (if_id_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL rst_addr: got %h want 00400000", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4: got %h want 0", if_id_pc_plus4); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL boot_req: got %b want 0", bus.imem_req); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL fetch_req: got %b want 1", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL fetch_addr0: got %h want 00400000", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid0: got %b want 0", if_id_valid); end
    @(negedge clk);
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL s1_valid: got %b want 1", if_id_valid); end
    total++; if (if_id_instr !== 32'h0040_0000) begin bad++; $display("FAIL s1_instr: got %h want 00400000", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0040_0004) begin bad++; $display("FAIL s1_pc4: got %h want 00400004", if_id_pc_plus4); end
    total++; if (bus.imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL s1_addr: got %h want 00400004", bus.imem_addr); end
    @(negedge clk);
    total++; if (if_id_instr !== 32'h0440_0004) begin bad++; $display("FAIL s2_instr: got %h want 04400004", if_id_instr); end
    total++; if (if_id_op !== 6'h01) begin bad++; $display("FAIL s2_op: got %h want 01", if_id_op); end
    total++; if (if_id_pc_plus4 !== 32'h0040_0008) begin bad++; $display("FAIL s2_pc4: got %h want 00400008", if_id_pc_plus4); end
    total++; if (bus.imem_addr !== 32'h0040_0008) begin bad++; $display("FAIL s2_addr: got %h want 00400008", bus.imem_addr); end
  endtask

  task automatic test_wait_states();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.imem_addr !== 32'h0040_0008) begin bad++; $display("FAIL wait_addr%0d: got %h want 00400008", i, bus.imem_addr); end
      total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL wait_valid%0d: got %b want 0", i, if_id_valid); end
      total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL wait_req%0d: got %b want 1", i, bus.imem_req); end
    end
    bus.imem_ready = 1'b1;
    @(negedge clk);
    total++; if (if_id_instr !== 32'h0840_0008) begin bad++; $display("FAIL wait_instr: got %h want 08400008", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0040_000C) begin bad++; $display("FAIL wait_pc4: got %h want 0040000c", if_id_pc_plus4); end
  endtask

  task automatic test_stall();
    ovr_en   = 1'b1;
    ovr_word = 32'h8C08_0004;
    stall    = 1'b1;
    @(negedge clk);
    ovr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL hold_req%0d: got %b want 0", i, bus.imem_req); end
      total++; if (if_id_instr !== 32'h0840_0008) begin bad++; $display("FAIL hold_instr%0d: got %h want 08400008", i, if_id_instr); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL hold_valid%0d: got %b want 1", i, if_id_valid); end
      if (i == 0) @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if (if_id_instr !== 32'h8C08_0004) begin bad++; $display("FAIL skid_instr: got %h want 8c080004", if_id_instr); end
    total++; if (if_id_op !== 6'h23) begin bad++; $display("FAIL skid_op: got %h want 23", if_id_op); end
    total++; if (if_id_pc_plus4 !== 32'h0040_0010) begin bad++; $display("FAIL skid_pc4: got %h want 00400010", if_id_pc_plus4); end
    total++; if (bus.imem_addr !== 32'h0040_0010) begin bad++; $display("FAIL skid_addr: got %h want 00400010", bus.imem_addr); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL skid_req: got %b want 1", bus.imem_req); end
    @(negedge clk);
    total++; if (if_id_instr !== 32'h1040_0010) begin bad++; $display("FAIL after_skid_instr: got %h want 10400010", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0040_0014) begin bad++; $display("FAIL after_skid_pc4: got %h want 00400014", if_id_pc_plus4); end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rh_req: got %b want 0", bus.imem_req); end
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0100;
    @(negedge clk);
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rh_valid: got %b want 0", if_id_valid); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL rh_instr: got %h want 0", if_id_instr); end
    total++; if (bus.imem_addr !== 32'h0040_0100) begin bad++; $display("FAIL rh_addr: got %h want 00400100", bus.imem_addr); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rh_req2: got %b want 1", bus.imem_req); end
    redirect = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    total++; if (if_id_instr !== 32'h0040_0100) begin bad++; $display("FAIL rh_new_instr: got %h want 00400100", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0040_0104) begin bad++; $display("FAIL rh_new_pc4: got %h want 00400104", if_id_pc_plus4); end
  endtask

  task automatic test_drain();
    bus.imem_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0040_0200;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0040_0104) begin bad++; $display("FAIL dr_addr0: got %h want 00400104", bus.imem_addr); end
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL dr_req0: got %b want 1", bus.imem_req); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL dr_valid0: got %b want 0", if_id_valid); end
    redirect_pc = 32'h0040_0300;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0040_0104) begin bad++; $display("FAIL dr_addr1: got %h want 00400104", bus.imem_addr); end
    redirect       = 1'b0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0040_0300) begin bad++; $display("FAIL dr_target: got %h want 00400300", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL dr_stale: got %b want 0", if_id_valid); end
    @(negedge clk);
    total++; if (if_id_instr !== 32'h0040_0300) begin bad++; $display("FAIL dr_instr: got %h want 00400300", if_id_instr); end
    total++; if (if_id_pc_plus4 !== 32'h0040_0304) begin bad++; $display("FAIL dr_pc4: got %h want 00400304", if_id_pc_plus4); end
    // redirect arriving in the same cycle as the stale response wins
    bus.imem_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0040_0400;
    @(negedge clk);
    bus.imem_ready = 1'b1;
    redirect_pc    = 32'h0040_0500;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0040_0500) begin bad++; $display("FAIL dr_same_cycle: got %h want 00400500", bus.imem_addr); end
    redirect = 1'b0;
  endtask

  task automatic test_align_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0203;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0040_0200) begin bad++; $display("FAIL align_addr: got %h want 00400200", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL align_valid: got %b want 0", if_id_valid); end
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0: got %h want fffffffc", bus.imem_addr); end
    redirect = 1'b0;
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr: got %h want 00000000", bus.imem_addr); end
    total++; if (if_id_pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 00000000", if_id_pc_plus4); end
    total++; if (if_id_instr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instr: got %h want fffffffc", if_id_instr); end
    total++; if (if_id_op !== 6'h3F) begin bad++; $display("FAIL wrap_op: got %h want 3f", if_id_op); end
  endtask

  task automatic test_reset_async();
    bus.imem_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL arst_req: got %b want 0", bus.imem_req); end
    total++; if (bus.imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL arst_addr: got %h want 00400000", bus.imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", if_id_valid); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL arst_instr: got %h want 0", if_id_instr); end
    @(negedge clk);
    reset          = 1'b1;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL arst_restart_req: got %b want 1", bus.imem_req); end
    @(negedge clk);
    total++; if (if_id_instr !== 32'h0040_0000) begin bad++; $display("FAIL arst_restart_instr: got %h want 00400000", if_id_instr); end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    ovr_en         = 1'b0;
    ovr_word       = 32'h0;
    bus.imem_ready = 1'b1;
    test_reset();
    test_stream();
    test_wait_states();
    test_stall();
    test_redirect_hold();
    test_drain();
    test_align_wrap();
    test_reset_async();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
